// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory port arbiter: FSM states and owner encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_L = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } owner_t;

  // Bit positions in the two-entry request/grant vectors.
  localparam int REQ_FETCH  = 0;
  localparam int REQ_LOADER = 1;

  // Saturation value for the optional wait-cycle counters.
  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on contention the one not served last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with memory readiness.
module rr_pick2
  import imem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Contention goes to the side that did not own the previous access.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (last == LOADER) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates a fetch port and a loader port onto one single-outstanding memory port.
// Latency: grant is combinational in IDLE; read data returns one cycle after mem_valid.
// Backpressure: no grant while mem_ready is low or an access is in flight; optional macro IMEM_ARB_PERF_EN adds wait counters.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
)
(
  input  logic                    clock,
  input  logic                    reset,
  // fetch side
  input  logic                    f_read,
  input  logic [ADDRESS_BITS-1:0] f_address,
  input  logic                    f_flush,
  output logic                    f_grant,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  output logic                    f_valid,
  // loader side
  input  logic                    l_read,
  input  logic                    l_write,
  input  logic [ADDRESS_BITS-1:0] l_address,
  input  logic [DATA_WIDTH-1:0]   l_wdata,
  output logic                    l_grant,
  output logic [DATA_WIDTH-1:0]   l_rdata,
  output logic                    l_valid,
  // memory side
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_valid,
  input  logic                    mem_ready
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]             f_wait_cycles,
  output logic [31:0]             l_wait_cycles
`endif
);

  arb_state_t              r_state;
  owner_t                  r_last_owner;
  logic                    r_drop;
  logic                    r_f_valid;
  logic                    r_l_valid;
  logic [DATA_WIDTH-1:0]   r_f_rdata;
  logic [DATA_WIDTH-1:0]   r_l_rdata;

  logic [1:0]              w_req;
  logic [1:0]              w_pick;
  logic                    w_issue;
  logic                    w_gnt_f;
  logic                    w_gnt_l;

  // Loader read+write together is a write, so the loader request is simply the OR.
  assign w_req[REQ_FETCH]  = f_read;
  assign w_req[REQ_LOADER] = l_read | l_write;

  rr_pick2 u_rr_pick2 (
    .req  (w_req),
    .last (r_last_owner),
    .gnt  (w_pick)
  );

  // Grants only exist in IDLE with a ready memory, and never while reset is held.
  assign w_issue = ~reset & (r_state == IDLE) & mem_ready;
  assign w_gnt_f = w_issue & w_pick[REQ_FETCH];
  assign w_gnt_l = w_issue & w_pick[REQ_LOADER];

  assign f_grant     = w_gnt_f;
  assign l_grant     = w_gnt_l;
  assign mem_read    = w_gnt_f | (w_gnt_l & ~l_write);
  assign mem_write   = w_gnt_l & l_write;
  assign mem_address = w_gnt_f ? f_address : l_address;
  assign mem_wdata   = l_wdata;

  assign f_valid = r_f_valid;
  assign l_valid = r_l_valid;
  assign f_rdata = r_f_rdata;
  assign l_rdata = r_l_rdata;

  // Access FSM: issue in IDLE, wait for mem_valid, register the response; a flush during a fetch drops its result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= LOADER;
      r_drop       <= 1'b0;
      r_f_valid    <= 1'b0;
      r_l_valid    <= 1'b0;
      r_f_rdata    <= '0;
      r_l_rdata    <= '0;
    end else begin
      r_f_valid <= 1'b0;
      r_l_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // A flush here (even alongside a fetch grant) must not cancel anything.
          r_drop <= 1'b0;
          if (w_gnt_f) begin
            r_state      <= BUSY_F;
            r_last_owner <= FETCH;
          end else if (w_gnt_l) begin
            r_state      <= BUSY_L;
            r_last_owner <= LOADER;
          end
        end
        BUSY_F: begin
          if (f_flush) begin
            r_drop <= 1'b1;
          end
          if (mem_valid) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            // A flush on the completion cycle itself still kills the response.
            if (!(r_drop || f_flush)) begin
              r_f_valid <= 1'b1;
              r_f_rdata <= mem_rdata;
            end
          end
        end
        BUSY_L: begin
          if (mem_valid) begin
            r_state   <= IDLE;
            r_l_valid <= 1'b1;
            r_l_rdata <= mem_rdata;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] r_f_wait;
  logic [31:0] r_l_wait;

  // Count cycles each side asks without being granted, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_f_wait <= '0;
      r_l_wait <= '0;
    end else begin
      if (w_req[REQ_FETCH] && !w_gnt_f && (r_f_wait != PERF_MAX)) begin
        r_f_wait <= r_f_wait + 32'd1;
      end
      if (w_req[REQ_LOADER] && !w_gnt_l && (r_l_wait != PERF_MAX)) begin
        r_l_wait <= r_l_wait + 32'd1;
      end
    end
  end

  assign f_wait_cycles = r_f_wait;
  assign l_wait_cycles = r_l_wait;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a response scoreboard.
// Latency: grants checked in the issue cycle; responses expected one cycle after mem_valid.
// Backpressure: exercises mem_ready low, busy periods, flush drops and reset mid-access.
module tb_imem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          f_read, f_flush, f_grant, f_valid;
  logic [AW-1:0] f_address;
  logic [DW-1:0] f_rdata;
  logic          l_read, l_write, l_grant, l_valid;
  logic [AW-1:0] l_address;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_read, mem_write, mem_valid, mem_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]   f_wait_cycles, l_wait_cycles;
`endif

  imem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .f_read      (f_read),
    .f_address   (f_address),
    .f_flush     (f_flush),
    .f_grant     (f_grant),
    .f_rdata     (f_rdata),
    .f_valid     (f_valid),
    .l_read      (l_read),
    .l_write     (l_write),
    .l_address   (l_address),
    .l_wdata     (l_wdata),
    .l_grant     (l_grant),
    .l_rdata     (l_rdata),
    .l_valid     (l_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready)
`ifdef IMEM_ARB_PERF_EN
    ,
    .f_wait_cycles (f_wait_cycles),
    .l_wait_cycles (l_wait_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_l;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the expected queue.
  always @(negedge clock) begin
    resp_t e;
    if (f_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_f_valid", {63'd0, f_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind_f", {63'd0, e.is_l}, 64'd0);
        check("f_rdata", {32'd0, f_rdata}, {32'd0, e.data});
      end
    end
    if (l_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_l_valid", {63'd0, l_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind_l", {63'd0, e.is_l}, 64'd1);
        check("l_rdata", {32'd0, l_rdata}, {32'd0, e.data});
      end
    end
  end

  task automatic clear_reqs();
    f_read  = 1'b0;
    f_flush = 1'b0;
    l_read  = 1'b0;
    l_write = 1'b0;
  endtask

  // Holds reset for two clocks with requests pending; nothing may be granted meanwhile.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; f_read = 1'b1; l_write = 1'b1; mem_ready = 1'b1;
    #1;
    check("rst_f_grant", {63'd0, f_grant}, 64'd0);
    check("rst_l_grant", {63'd0, l_grant}, 64'd0);
    check("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_mem_write", {63'd0, mem_write}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clear_reqs();
  endtask

  // Called just after inputs are driven at a negedge; checks the combinational issue.
  task automatic issue_check(input string tag, input logic ef, input logic el, input logic emr,
                             input logic emw, input logic [AW-1:0] ea, input logic chk_wd,
                             input logic [DW-1:0] ewd);
    #1;
    check({tag, "_f_grant"}, {63'd0, f_grant}, {63'd0, ef});
    check({tag, "_l_grant"}, {63'd0, l_grant}, {63'd0, el});
    check({tag, "_mem_read"}, {63'd0, mem_read}, {63'd0, emr});
    check({tag, "_mem_write"}, {63'd0, mem_write}, {63'd0, emw});
    if (ef || el) check({tag, "_mem_address"}, {44'd0, mem_address}, {44'd0, ea});
    if (chk_wd) check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, ewd});
  endtask

  // Busy phase: lat idle busy cycles then mem_valid; flush_cyc selects which cycle has f_flush high (-1 none).
  task automatic complete(input logic [DW-1:0] d, input int lat, input int flush_cyc,
                          input logic push_f, input logic push_l, input logic drop_req);
    resp_t r;
    r.data = d;
    if (push_f) begin r.is_l = 1'b0; exp_q.push_back(r); end
    if (push_l) begin r.is_l = 1'b1; exp_q.push_back(r); end
    for (int i = 0; i <= lat; i++) begin
      @(negedge clock);
      if (drop_req) begin
        f_read = 1'b0; l_read = 1'b0; l_write = 1'b0;
      end
      f_flush   = (i == flush_cyc);
      mem_valid = (i == lat);
      mem_rdata = d;
      #1;
      check("busy_f_grant", {63'd0, f_grant}, 64'd0);
      check("busy_l_grant", {63'd0, l_grant}, 64'd0);
      check("busy_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
    end
    @(negedge clock);
    mem_valid = 1'b0;
    f_flush   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_reqs();
    f_address = '0; l_address = '0; l_wdata = '0;
    mem_rdata = '0; mem_valid = 1'b0; mem_ready = 1'b1;

    do_reset();
    #1;
    check("rst_f_valid", {63'd0, f_valid}, 64'd0);
    check("rst_l_valid", {63'd0, l_valid}, 64'd0);
    check("rst_f_rdata", {32'd0, f_rdata}, 64'd0);
    check("rst_l_rdata", {32'd0, l_rdata}, 64'd0);

    // Basic fetch after reset.
    @(negedge clock);
    f_read = 1'b1; f_address = 20'h00010;
    issue_check("fetch1", 1'b1, 1'b0, 1'b1, 1'b0, 20'h00010, 1'b0, '0);
    complete(32'h0000_0013, 0, -1, 1'b1, 1'b0, 1'b1);

    // Loader write; read-and-write together behaves as a write.
    @(negedge clock);
    l_write = 1'b1; l_read = 1'b1; l_address = 20'h00040; l_wdata = 32'hDEAD_BEEF;
    issue_check("lwrite", 1'b0, 1'b1, 1'b0, 1'b1, 20'h00040, 1'b1, 32'hDEAD_BEEF);
    complete(32'h0000_5A5A, 2, -1, 1'b0, 1'b1, 1'b1);

    // Stray mem_valid in IDLE must be ignored.
    @(negedge clock);
    mem_valid = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clock);
    mem_valid = 1'b0;

    // Contention: last owner was the loader, so F,L,F,L.
    @(negedge clock);
    f_read = 1'b1; f_address = 20'h00100;
    l_read = 1'b1; l_address = 20'h00200;
    for (int k = 0; k < 4; k++) begin
      logic fw;
      fw = (k % 2 == 0);
      issue_check("rr", fw, ~fw, 1'b1, 1'b0, fw ? 20'h00100 : 20'h00200, 1'b0, '0);
      complete(32'h1000_0000 + k, 1, -1, fw, ~fw, 1'b0);
    end
    clear_reqs();

    // Flush one cycle before completion drops the fetch.
    @(negedge clock);
    f_read = 1'b1; f_address = 20'h00300;
    issue_check("flush_early", 1'b1, 1'b0, 1'b1, 1'b0, 20'h00300, 1'b0, '0);
    complete(32'hBAD0_0001, 2, 1, 1'b0, 1'b0, 1'b1);

    // Next fetch returns normally.
    @(negedge clock);
    f_read = 1'b1; f_address = 20'h00304;
    issue_check("after_flush", 1'b1, 1'b0, 1'b1, 1'b0, 20'h00304, 1'b0, '0);
    complete(32'h0000_0093, 1, -1, 1'b1, 1'b0, 1'b1);

    // Flush on the mem_valid cycle still drops; rdata holds the previous value.
    @(negedge clock);
    f_read = 1'b1; f_address = 20'h00308;
    issue_check("flush_late", 1'b1, 1'b0, 1'b1, 1'b0, 20'h00308, 1'b0, '0);
    complete(32'hBAD0_0002, 1, 1, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    check("f_rdata_hold", {32'd0, f_rdata}, 64'h0000_0093);
    check("l_rdata_hold", {32'd0, l_rdata}, 64'h1000_0003);

    // Flush coincident with the grant does not cancel it.
    @(negedge clock);
    f_read = 1'b1; f_flush = 1'b1; f_address = 20'h0030C;
    issue_check("flush_grant", 1'b1, 1'b0, 1'b1, 1'b0, 20'h0030C, 1'b0, '0);
    complete(32'h0000_00B7, 0, -1, 1'b1, 1'b0, 1'b1);

    // Reset during a loader access, then a stray mem_valid.
    @(negedge clock);
    l_read = 1'b1; l_address = 20'h00500;
    issue_check("lread_abort", 1'b0, 1'b1, 1'b1, 1'b0, 20'h00500, 1'b0, '0);
    @(negedge clock);
    l_read = 1'b0;
    do_reset();
    mem_valid = 1'b1; mem_rdata = 32'hCAFE_CAFE;
    #1;
    check("abort_l_rdata", {32'd0, l_rdata}, 64'd0);
    @(negedge clock);
    mem_valid = 1'b0;
    // Back in IDLE with last_owner reset to LOADER: contention goes to fetch.
    f_read = 1'b1; f_address = 20'h00600;
    l_read = 1'b1; l_address = 20'h00700;
    issue_check("post_abort", 1'b1, 1'b0, 1'b1, 1'b0, 20'h00600, 1'b0, '0);
    complete(32'h0000_0EEE, 0, -1, 1'b1, 1'b0, 1'b1);

    // Memory not ready for 5 cycles: no grant.
    do_reset();
    f_read = 1'b1; f_address = 20'h00800; mem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("not_ready_f_grant", {63'd0, f_grant}, 64'd0);
      check("not_ready_mem_read", {63'd0, mem_read}, 64'd0);
      @(negedge clock);
    end
    f_read = 1'b0;
`ifdef IMEM_ARB_PERF_EN
    #1;
    check("f_wait_cycles", {32'd0, f_wait_cycles}, 64'd5);
    check("l_wait_cycles", {32'd0, l_wait_cycles}, 64'd0);
`endif
    mem_ready = 1'b1;

    repeat (3) @(negedge clock);
    check("resp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
